// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32 control sequencer: FETCH/DECODE/EXEC/MEM/WB with ready-handshaked
// memories, handshake timeout, illegal-opcode trap and a retired-instruction counter.
module multicycle_control_fsm #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             dmem_req,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       ALUOp,
    output logic             illegal,
    output logic             timeout,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               run_q;
    logic [6:0]         op_q;
    logic [6:0]         op_d;
    logic [WAIT_W-1:0]  wait_q;
    logic [WAIT_W-1:0]  wait_d;
    logic [CNT_W-1:0]   instret_q;
    logic               illegal_q;
    logic               timeout_q;
    logic               retire;
    logic               illegal_set;
    logic               timeout_set;
    logic               op_lw;
    logic               op_sw;
    logic               op_i;
    logic               op_supported;
    logic               expire;

    assign op_lw        = (op_q == OP_LW);
    assign op_sw        = (op_q == OP_SW);
    assign op_i         = (op_q == OP_I);
    assign op_supported = (opcode == OP_R) || (opcode == OP_I) ||
                          (opcode == OP_LW) || (opcode == OP_SW);
    // This no-ready cycle is the TIMEOUT-th consecutive one; a ready here still wins.
    assign expire       = (wait_q == WAIT_W'(TIMEOUT - 1));

    // State register; run_q keeps every output low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= '0;
            wait_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            wait_q <= wait_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            if (illegal_set) begin
                illegal_q <= 1'b1;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Next-state, wait counter, opcode capture and retire decision.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wait_d      = '0;
        retire      = 1'b0;
        illegal_set = 1'b0;
        timeout_set = 1'b0;
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        state_d = S_DECODE;
                    end else if (expire) begin
                        state_d     = S_TRAP;
                        timeout_set = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    op_d = opcode;
                    if (op_supported) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d     = S_TRAP;
                        illegal_set = 1'b1;
                    end
                end
                S_EXEC: begin
                    state_d = (op_lw || op_sw) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (op_sw) begin
                            state_d = S_FETCH;
                            retire  = 1'b1;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (expire) begin
                        state_d     = S_TRAP;
                        timeout_set = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
                S_TRAP: begin
                    state_d = S_TRAP;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // Datapath controls decoded from the current state and the captured opcode.
    always_comb begin
        imem_req = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        dmem_req = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUOp    = 2'b00;
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                S_EXEC: begin
                    ALUSrc = op_lw || op_sw || op_i;
                    ALUOp  = {op_i, 1'b0};
                end
                S_MEM: begin
                    ALUSrc   = op_lw || op_sw || op_i;
                    ALUOp    = {op_i, 1'b0};
                    dmem_req = 1'b1;
                    MemRead  = op_lw;
                    MemWrite = op_sw;
                    pc_write = op_sw && dmem_ready;
                end
                S_WB: begin
                    ALUSrc   = op_lw || op_sw || op_i;
                    ALUOp    = {op_i, 1'b0};
                    RegWrite = 1'b1;
                    MemtoReg = op_lw;
                    pc_write = 1'b1;
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    assign state   = state_q;
    assign instret = instret_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: a per-instruction cycle-sequence model
// generates stimulus plus expected outputs, which each scenario task replays and compares.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TMO   = 8;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // Control bit positions: {imem_req, ir_write, pc_write, dmem_req, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite}
    localparam logic [8:0] C_IREQ = 9'h100;
    localparam logic [8:0] C_IRW  = 9'h080;
    localparam logic [8:0] C_PCW  = 9'h040;
    localparam logic [8:0] C_DREQ = 9'h020;
    localparam logic [8:0] C_ASRC = 9'h010;
    localparam logic [8:0] C_M2R  = 9'h008;
    localparam logic [8:0] C_RW   = 9'h004;
    localparam logic [8:0] C_MR   = 9'h002;
    localparam logic [8:0] C_MW   = 9'h001;

    logic             clk;
    logic             reset_n;
    logic [6:0]       opcode;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_write;
    logic             pc_write;
    logic             dmem_req;
    logic             ALUSrc;
    logic             MemtoReg;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic [1:0]       ALUOp;
    logic             illegal;
    logic             timeout;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;
    logic [19:0]      obs;

    multicycle_control_fsm #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .dmem_req(dmem_req),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp),
        .illegal(illegal), .timeout(timeout), .state(state), .instret(instret)
    );

    assign obs = {state, imem_req, ir_write, pc_write, dmem_req, ALUSrc, MemtoReg,
                  RegWrite, MemRead, MemWrite, ALUOp, illegal, timeout, instret};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        imr;
        logic        dmr;
        logic [6:0]  opc;
        logic [19:0] exp;
    } cyc_t;

    cyc_t       q[$];
    logic [3:0] m_instret;
    logic       m_illegal;
    logic       m_timeout;
    int         total;
    int         bad;

    function automatic logic rb();
        return 1'($urandom());
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom());
    endfunction

    function automatic logic [19:0] mk(input logic [2:0] st, input logic [8:0] ctl, input logic [1:0] aop);
        return {st, ctl, aop, m_illegal, m_timeout, m_instret};
    endfunction

    task automatic push(input logic imr, input logic dmr, input logic [6:0] opc, input logic [19:0] e);
        cyc_t c;
        c.imr = imr;
        c.dmr = dmr;
        c.opc = opc;
        c.exp = e;
        q.push_back(c);
    endtask

    // One instruction as a cycle sequence; waits >= TMO model a handshake that never completes.
    task automatic model_instr(input logic [6:0] op, input int wi, input int wd);
        logic       is_lw;
        logic       is_sw;
        logic       is_i;
        logic       legal;
        logic [8:0] a;
        logic [1:0] aop;
        is_lw = (op == OP_LW);
        is_sw = (op == OP_SW);
        is_i  = (op == OP_I);
        legal = is_lw || is_sw || is_i || (op == OP_R);
        a     = (is_lw || is_sw || is_i) ? C_ASRC : 9'h000;
        aop   = is_i ? 2'b10 : 2'b00;
        for (int k = 0; k < ((wi < TMO) ? wi : TMO); k++)
            push(1'b0, rb(), rop(), mk(3'd0, C_IREQ, 2'b00));
        if (wi >= TMO) begin
            m_timeout = 1'b1;
            return;
        end
        push(1'b1, rb(), rop(), mk(3'd0, C_IREQ | C_IRW, 2'b00));
        push(rb(), rb(), op, mk(3'd1, 9'h000, 2'b00));
        if (!legal) begin
            m_illegal = 1'b1;
            return;
        end
        push(rb(), rb(), rop(), mk(3'd2, a, aop));
        if (is_lw || is_sw) begin
            for (int k = 0; k < ((wd < TMO) ? wd : TMO); k++)
                push(rb(), 1'b0, rop(), mk(3'd3, C_DREQ | a | (is_lw ? C_MR : C_MW), aop));
            if (wd >= TMO) begin
                m_timeout = 1'b1;
                return;
            end
            push(rb(), 1'b1, rop(), mk(3'd3, C_DREQ | a | (is_lw ? C_MR : (C_MW | C_PCW)), aop));
            if (is_sw) begin
                m_instret = m_instret + 4'd1;
                return;
            end
        end
        push(rb(), rb(), rop(), mk(3'd4, C_PCW | C_RW | a | (is_lw ? C_M2R : 9'h000), aop));
        m_instret = m_instret + 4'd1;
    endtask

    task automatic model_trap(input int n);
        for (int k = 0; k < n; k++)
            push(rb(), rb(), rop(), mk(3'd5, 9'h000, 2'b00));
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        opcode     = '0;
        q.delete();
        m_instret = '0;
        m_illegal = 1'b0;
        m_timeout = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        cyc_t c;
        int   n;
        do_reset();
        reset_n = 1'b0;
        #2;
        total++;
        if (obs !== 20'h0) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", obs, 20'h0);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 20'h0) begin
            bad++;
            $display("FAIL reset_release_pre_edge got=%h want=%h", obs, 20'h0);
        end
        model_instr(OP_R, 2, 0);
        model_instr(OP_SW, 0, 3);
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk); #1;
            imem_ready = c.imr; dmem_ready = c.dmr; opcode = c.opc;
            @(negedge clk);
            total++;
            if (obs !== c.exp) begin
                bad++;
                $display("FAIL reset_pre cyc=%0d got=%h want=%h", n, obs, c.exp);
            end
            n++;
            if (c.exp[19:17] == 3'd3) break;
        end
        #1 reset_n = 1'b0;
        #1;
        total++;
        if ({MemWrite, dmem_req, instret, obs} !== {1'b0, 1'b0, 4'd0, 20'h0}) begin
            bad++;
            $display("FAIL reset_mid_mem got=%h want=%h", obs, 20'h0);
        end
        q.delete();
        m_instret = '0;
        m_illegal = 1'b0;
        m_timeout = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 20'h0) begin
            bad++;
            $display("FAIL reset_rerelease got=%h want=%h", obs, 20'h0);
        end
        model_instr(OP_R, 0, 0);
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk); #1;
            imem_ready = c.imr; dmem_ready = c.dmr; opcode = c.opc;
            @(negedge clk);
            total++;
            if (obs !== c.exp) begin
                bad++;
                $display("FAIL reset_post cyc=%0d got=%h want=%h", n, obs, c.exp);
            end
            n++;
        end
    endtask

    task automatic test_instr_mix();
        cyc_t c;
        int   n;
        model_instr(OP_R, 0, 0);
        model_instr(OP_LW, 0, 3);
        model_instr(OP_SW, 0, 0);
        model_instr(OP_I, 0, 0);
        model_instr(OP_R, TMO - 1, 0);
        model_instr(OP_SW, 1, TMO - 1);
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk); #1;
            imem_ready = c.imr; dmem_ready = c.dmr; opcode = c.opc;
            @(negedge clk);
            total++;
            if (obs !== c.exp) begin
                bad++;
                $display("FAIL instr_mix cyc=%0d got=%h want=%h", n, obs, c.exp);
            end
            n++;
        end
    endtask

    task automatic test_random();
        cyc_t       c;
        int         n;
        logic [6:0] ops [4];
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LW; ops[3] = OP_SW;
        for (int k = 0; k < 30; k++)
            model_instr(ops[$urandom_range(0, 3)], int'($urandom_range(0, TMO - 1)),
                        int'($urandom_range(0, TMO - 1)));
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk); #1;
            imem_ready = c.imr; dmem_ready = c.dmr; opcode = c.opc;
            @(negedge clk);
            total++;
            if (obs !== c.exp) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", n, obs, c.exp);
            end
            n++;
        end
    endtask

    task automatic test_wrap();
        cyc_t c;
        int   n;
        do_reset();
        for (int k = 0; k < 16; k++) model_instr(OP_R, 0, 0);
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk); #1;
            imem_ready = c.imr; dmem_ready = c.dmr; opcode = c.opc;
            @(negedge clk);
            total++;
            if (obs !== c.exp) begin
                bad++;
                $display("FAIL wrap cyc=%0d got=%h want=%h", n, obs, c.exp);
            end
            n++;
        end
        @(posedge clk); #1;
        imem_ready = 1'b0;
        total++;
        if ({state, instret} !== {3'd0, 4'd0}) begin
            bad++;
            $display("FAIL wrap_instret got=%0d want=0 state=%0d", instret, state);
        end
    endtask

    task automatic test_illegal();
        cyc_t       c;
        int         n;
        logic [6:0] bad_op;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            bad_op = OP_BR;
            if (pass == 1) begin
                bad_op = rop();
                while (bad_op == OP_R || bad_op == OP_I || bad_op == OP_LW || bad_op == OP_SW)
                    bad_op = rop();
            end
            model_instr(OP_R, 0, 0);
            model_instr(bad_op, 1, 0);
            model_trap(20);
            n = 0;
            while (q.size() > 0) begin
                c = q.pop_front();
                @(posedge clk); #1;
                imem_ready = c.imr; dmem_ready = c.dmr; opcode = c.opc;
                @(negedge clk);
                total++;
                if (obs !== c.exp) begin
                    bad++;
                    $display("FAIL illegal op=%b cyc=%0d got=%h want=%h", bad_op, n, obs, c.exp);
                end
                n++;
            end
        end
    endtask

    task automatic test_timeout();
        cyc_t c;
        int   n;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            model_instr(OP_I, 0, 0);
            if (pass == 0) model_instr(OP_R, TMO, 0);
            else           model_instr(OP_LW, 0, TMO);
            model_trap(12);
            n = 0;
            while (q.size() > 0) begin
                c = q.pop_front();
                @(posedge clk); #1;
                imem_ready = c.imr; dmem_ready = c.dmr; opcode = c.opc;
                @(negedge clk);
                total++;
                if (obs !== c.exp) begin
                    bad++;
                    $display("FAIL timeout pass=%0d cyc=%0d got=%h want=%h", pass, n, obs, c.exp);
                end
                n++;
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        opcode     = '0;
        m_instret  = '0;
        m_illegal  = 1'b0;
        m_timeout  = 1'b0;
        test_reset();
        test_instr_mix();
        test_random();
        test_wrap();
        test_illegal();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
